// File: rtl/audio_pkg.sv
// Shared constants, sample-pair type and slot-bit helper for the I2S transmitter.
package audio_pkg;

  localparam int FRAME_CYCLES = 256;
  localparam int SLOT_BITS    = 32;
  localparam int SCLK_DIV     = 4;
  localparam int MAX_SAMPLE_W = 32;

  // Samples narrower than MAX_SAMPLE_W sit in the low bits, zero-extended.
  typedef struct packed {
    logic [MAX_SAMPLE_W-1:0] left;
    logic [MAX_SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // Slot 0 is the I2S delay bit; slots 1..width carry the sample MSB first.
  function automatic logic slot_bit(input logic [MAX_SAMPLE_W-1:0] sample,
                                    input logic [4:0]              slot,
                                    input int                      width);
    logic [4:0] idx;
    slot_bit = 1'b0;
    idx      = 5'(width - int'(slot));
    if (slot != 5'd0 && int'(slot) <= width) begin
      slot_bit = sample[idx];
    end
  endfunction

endpackage

// File: rtl/audio_i2s_fifo.sv
// Synchronous sample-pair FIFO with full/empty flags and a registered head word.
module audio_i2s_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign rdata      = head_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Head always mirrors the entry at the read pointer after the edge,
      // including the write that lands in a FIFO that is draining to empty.
      if (do_pop && do_push && count == (AW+1)'(1)) begin
        head_q <= wdata;
      end else if (do_pop) begin
        head_q <= mem[rd_ptr_inc];
      end else if (do_push && empty) begin
        head_q <= wdata;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S serializer: 256-cycle frame counter, shadow sample pair, slot mux and pin flops.
// Optional feature macro: AUDIO_I2S_UNDERRUN_CNT_EN builds the saturating underrun counter.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_audio,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                audio_sclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic                underrun,
  output logic [15:0]         underrun_count
);

  localparam int CNT_W    = $clog2(FRAME_CYCLES);
  localparam int SCLK_BIT = $clog2(SCLK_DIV) - 1;
  localparam int SLOT_W   = $clog2(SLOT_BITS);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  frame_end;
  logic                  rst_done_q;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_head;
  stereo_sample_t        shadow_q;
  stereo_sample_t        shadow_next;
  logic [SLOT_W-1:0]     slot_next;
  logic                  dac_next;
  logic                  sclk_q;
  logic                  lrck_q;
  logic                  dac_q;

  // Handshake: a pair transfers on every rising clk_audio edge where s_valid
  // and s_ready are both high; s_ready depends only on registered FIFO state.
  assign s_ready   = rst_done_q && !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign frame_end = (cnt == {CNT_W{1'b1}});
  assign fifo_pop  = frame_end && !fifo_empty;
  assign underrun  = frame_end && fifo_empty;
  assign cnt_next  = cnt + CNT_W'(1);

  audio_i2s_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_audio),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({s_left, s_right}),
    .pop     (fifo_pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // At frame end the shadows take the FIFO head, or mute when nothing is queued.
  always_comb begin
    shadow_next = shadow_q;
    if (frame_end) begin
      shadow_next = '0;
      if (!fifo_empty) begin
        shadow_next.left  = MAX_SAMPLE_W'(fifo_head[2*SAMPLE_W-1:SAMPLE_W]);
        shadow_next.right = MAX_SAMPLE_W'(fifo_head[SAMPLE_W-1:0]);
      end
    end
  end

  // Pins are registered from next-cycle values so all three change together.
  always_comb begin
    slot_next = cnt_next[SCLK_BIT+SLOT_W:SCLK_BIT+1];
    dac_next  = slot_bit(cnt_next[CNT_W-1] ? shadow_next.right : shadow_next.left,
                         slot_next, SAMPLE_W);
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      rst_done_q <= 1'b0;
      shadow_q   <= '0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      rst_done_q <= 1'b1;
      shadow_q   <= shadow_next;
      sclk_q     <= cnt_next[SCLK_BIT];
      lrck_q     <= cnt_next[CNT_W-1];
      dac_q      <= dac_next;
    end
  end

  assign audio_sclk = sclk_q;
  assign audio_lrck = lrck_q;
  assign audio_dac  = dac_q;

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      urun_cnt_q <= '0;
    end else if (underrun && urun_cnt_q != 16'hFFFF) begin
      urun_cnt_q <= urun_cnt_q + 16'd1;
    end
  end

  assign underrun_count = urun_cnt_q;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-position reference model, directed scenarios and random pushes.
module tb_audio_i2s_tx;

  localparam int W     = 16;
  localparam int W24   = 24;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk_audio;
  logic reset_n;

  initial begin
    clk_audio = 1'b0;
    forever #5 clk_audio = ~clk_audio;
  end

  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_left;
  logic [W-1:0]   s_right;
  logic           audio_sclk;
  logic           audio_lrck;
  logic           audio_dac;
  logic           underrun;
  logic [15:0]    underrun_count;

  logic           s_valid24;
  logic           s_ready24;
  logic [W24-1:0] s_left24;
  logic [W24-1:0] s_right24;
  logic           sclk24;
  logic           lrck24;
  logic           dac24;
  logic           underrun24;
  logic [15:0]    underrun_count24;

  audio_i2s_tx #(.SAMPLE_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_audio      (clk_audio),
    .reset_n        (reset_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_left         (s_left),
    .s_right        (s_right),
    .audio_sclk     (audio_sclk),
    .audio_lrck     (audio_lrck),
    .audio_dac      (audio_dac),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  audio_i2s_tx #(.SAMPLE_W(W24), .FIFO_DEPTH(DEPTH)) dut24 (
    .clk_audio      (clk_audio),
    .reset_n        (reset_n),
    .s_valid        (s_valid24),
    .s_ready        (s_ready24),
    .s_left         (s_left24),
    .s_right        (s_right24),
    .audio_sclk     (sclk24),
    .audio_lrck     (lrck24),
    .audio_dac      (dac24),
    .underrun       (underrun24),
    .underrun_count (underrun_count24)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frame position, queued pairs, current shadow pair
  int             m_cnt  = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_left  = '0;
  logic [W-1:0]   m_right = '0;
  int             m_urun  = 0;

  initial begin
    forever begin
      @(posedge clk_audio or negedge reset_n);
      if (!reset_n) begin
        m_cnt = 0; exp_q.delete(); m_left = '0; m_right = '0; m_urun = 0;
      end else begin
        logic take;
        take = s_valid && (exp_q.size() < DEPTH);
        if (m_cnt == 255) begin
          if (exp_q.size() > 0) begin
            {m_left, m_right} = exp_q.pop_front();
          end else begin
            m_left = '0; m_right = '0;
            if (m_urun < 65535) m_urun++;
          end
        end
        if (take) exp_q.push_back({s_left, s_right});
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  function automatic logic exp_dac(input int c, input logic [W-1:0] l, input logic [W-1:0] r);
    int b;
    logic [W-1:0] s;
    logic [W-1:0] t;
    b = (c >> 2) % 32;
    s = (c >= 128) ? r : l;
    if (b < 1 || b > W) return 1'b0;
    t = s >> (W - b);
    return t[0];
  endfunction

  // expected 32-slot pattern of one channel: slot s carries sample bit (w-s)
  function automatic logic [31:0] slot_vec(input logic [31:0] sample, input int w);
    logic [31:0] v;
    logic [31:0] t;
    v = '0;
    for (int sl = 1; sl <= w; sl++) begin
      t = sample >> (w - sl);
      v = v | (32'(t[0]) << sl);
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_ucnt();
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    return 16'(m_urun);
`else
    return 16'd0;
`endif
  endfunction

  // driver tasks
  task automatic wait_cnt(input int k);
    int guard = 0;
    while (m_cnt != k && guard < 600) begin
      @(negedge clk_audio);
      guard++;
    end
    if (m_cnt != k) begin
      n_tests++; n_fail++;
      $display("FAIL wait_cnt: position %0d required %0d", m_cnt, k);
    end
  endtask

  task automatic drive_push(input logic [W-1:0] l, input logic [W-1:0] r);
    s_valid = 1'b1; s_left = l; s_right = r;
    @(negedge clk_audio);
    s_valid = 1'b0;
  endtask

  // samples the data pin while SCLK is high, for one whole frame
  task automatic capture_frame(input logic sel24, output logic [31:0] gl, output logic [31:0] gr);
    logic d;
    int   slot;
    gl = '0; gr = '0;
    for (int i = 0; i < 256; i++) begin
      if ((m_cnt % 4) == 2) begin
        d    = sel24 ? dac24 : audio_dac;
        slot = (m_cnt >> 2) % 32;
        if (m_cnt >= 128) gr = gr | (32'(d) << slot);
        else              gl = gl | (32'(d) << slot);
      end
      @(negedge clk_audio);
    end
  endtask

  // scenarios
  task automatic test_reset();
    s_valid = 0; s_left = '0; s_right = '0;
    s_valid24 = 0; s_left24 = '0; s_right24 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_audio);
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    n_tests++; if (audio_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", audio_sclk); end
    n_tests++; if (audio_lrck !== 1'b0) begin n_fail++; $display("FAIL reset_lrck: got %b want 0", audio_lrck); end
    n_tests++; if (audio_dac !== 1'b0) begin n_fail++; $display("FAIL reset_dac: got %b want 0", audio_dac); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_tests++; if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d want 0", underrun_count); end
    reset_n = 1'b1;
    @(negedge clk_audio);
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_idle();
    int   rises = 0, lr_rises = 0, lr_low = 0, pulses = 0, stray = 0, ones = 0, phase_err = 0, not_rdy = 0;
    logic prev_s, prev_l;
    prev_s = audio_sclk; prev_l = audio_lrck;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk_audio);
      if (audio_sclk && !prev_s) rises++;
      if (audio_lrck && !prev_l) lr_rises++;
      if (!audio_lrck) lr_low++;
      if (underrun) begin pulses++; if (m_cnt != 255) stray++; end
      if (audio_dac) ones++;
      if (!s_ready) not_rdy++;
      if (audio_sclk !== (((m_cnt >> 1) % 2) == 1) || audio_lrck !== (m_cnt >= 128)) phase_err++;
      prev_s = audio_sclk; prev_l = audio_lrck;
    end
    n_tests++; if (rises != 256) begin n_fail++; $display("FAIL idle_sclk_rises: got %0d want 256", rises); end
    n_tests++; if (lr_rises != 4) begin n_fail++; $display("FAIL idle_lrck_periods: got %0d want 4", lr_rises); end
    n_tests++; if (lr_low != 512) begin n_fail++; $display("FAIL idle_lrck_low: got %0d want 512", lr_low); end
    n_tests++; if (pulses != 4) begin n_fail++; $display("FAIL idle_underruns: got %0d want 4", pulses); end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL idle_underrun_pos: got %0d off-255 pulses want 0", stray); end
    n_tests++; if (ones != 0) begin n_fail++; $display("FAIL idle_dac: got %0d high cycles want 0", ones); end
    n_tests++; if (phase_err != 0) begin n_fail++; $display("FAIL idle_phase: got %0d bad cycles want 0", phase_err); end
    n_tests++; if (not_rdy != 0) begin n_fail++; $display("FAIL idle_ready: got %0d low cycles want 0", not_rdy); end
    n_tests++; if (underrun_count !== exp_ucnt()) begin n_fail++; $display("FAIL idle_ucnt: got %0d want %0d", underrun_count, exp_ucnt()); end
  endtask

  task automatic test_single_pair();
    logic [31:0] gl, gr;
    wait_cnt(10);
    drive_push(16'hA5F0, 16'h0F0F);
    wait_cnt(0);
    capture_frame(1'b0, gl, gr);
    n_tests++; if (gl !== slot_vec(32'hA5F0, W)) begin n_fail++; $display("FAIL pair_left: got %h want %h", gl, slot_vec(32'hA5F0, W)); end
    n_tests++; if (gr !== slot_vec(32'h0F0F, W)) begin n_fail++; $display("FAIL pair_right: got %h want %h", gr, slot_vec(32'h0F0F, W)); end
  endtask

  task automatic test_back_to_back();
    wait_cnt(20);
    for (int i = 0; i < 4; i++) drive_push(W'($urandom), W'($urandom));
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", s_ready); end
    wait_cnt(255);
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_at_pop: got %b want 0", s_ready); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_underrun: got %b want 0", underrun); end
    @(negedge clk_audio);
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop: got %b want 1", s_ready); end
    // three queued: push and pop together on the next frame end
    wait_cnt(255);
    drive_push(W'($urandom), W'($urandom));
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pushpop_ready: got %b want 1", s_ready); end
    drive_push(W'($urandom), W'($urandom));
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pushpop_count: got %b want 0", s_ready); end
  endtask

  task automatic test_random();
    logic e_sclk, e_lrck, e_dac, e_ur, e_rdy;
    for (int i = 0; i < 768; i++) begin
      e_sclk = ((m_cnt >> 1) % 2) == 1;
      e_lrck = m_cnt >= 128;
      e_dac  = exp_dac(m_cnt, m_left, m_right);
      e_ur   = (m_cnt == 255) && (exp_q.size() == 0);
      e_rdy  = exp_q.size() < DEPTH;
      n_tests++; if (audio_sclk !== e_sclk) begin n_fail++; $display("FAIL rnd_sclk cyc %0d: got %b want %b", i, audio_sclk, e_sclk); end
      n_tests++; if (audio_lrck !== e_lrck) begin n_fail++; $display("FAIL rnd_lrck cyc %0d: got %b want %b", i, audio_lrck, e_lrck); end
      n_tests++; if (audio_dac !== e_dac) begin n_fail++; $display("FAIL rnd_dac cyc %0d cnt %0d: got %b want %b", i, m_cnt, audio_dac, e_dac); end
      n_tests++; if (underrun !== e_ur) begin n_fail++; $display("FAIL rnd_underrun cyc %0d: got %b want %b", i, underrun, e_ur); end
      n_tests++; if (s_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", i, s_ready, e_rdy); end
      s_valid = ($urandom_range(0, 99) < 4);
      s_left  = W'($urandom);
      s_right = W'($urandom);
      @(negedge clk_audio);
    end
    s_valid = 1'b0;
    n_tests++; if (underrun_count !== exp_ucnt()) begin n_fail++; $display("FAIL rnd_ucnt: got %0d want %0d", underrun_count, exp_ucnt()); end
  endtask

  task automatic test_push_at_255();
    logic [W-1:0] pl, pr;
    logic [31:0]  gl, gr;
    logic         ur_end;
    int           guard = 0, ones = 0;
    while (exp_q.size() > 0 && guard < 2048) begin @(negedge clk_audio); guard++; end
    if (exp_q.size() > 0) begin n_tests++; n_fail++; $display("FAIL p255_drain: %0d entries left want 0", exp_q.size()); end
    pl = W'($urandom) | 16'h8001; pr = W'($urandom);
    wait_cnt(255);
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL p255_underrun: got %b want 1", underrun); end
    drive_push(pl, pr);
    ur_end = 1'bx;
    for (int i = 0; i < 256; i++) begin
      if (audio_dac) ones++;
      if (m_cnt == 255) ur_end = underrun;
      @(negedge clk_audio);
    end
    n_tests++; if (ones != 0) begin n_fail++; $display("FAIL p255_mute: got %0d high cycles want 0", ones); end
    n_tests++; if (ur_end !== 1'b0) begin n_fail++; $display("FAIL p255_pop: got underrun %b want 0", ur_end); end
    capture_frame(1'b0, gl, gr);
    n_tests++; if (gl !== slot_vec(32'(pl), W)) begin n_fail++; $display("FAIL p255_left: got %h want %h", gl, slot_vec(32'(pl), W)); end
    n_tests++; if (gr !== slot_vec(32'(pr), W)) begin n_fail++; $display("FAIL p255_right: got %h want %h", gr, slot_vec(32'(pr), W)); end
  endtask

  task automatic test_reset_mid();
    int ones = 0, pulses = 0;
    wait_cnt(5);
    for (int i = 0; i < 3; i++) drive_push(W'($urandom) | 16'h8000, W'($urandom) | 16'h8000);
    wait_cnt(100);
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", s_ready); end
    n_tests++; if (audio_sclk !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b want 0", audio_sclk); end
    n_tests++; if (audio_lrck !== 1'b0) begin n_fail++; $display("FAIL mid_lrck: got %b want 0", audio_lrck); end
    n_tests++; if (audio_dac !== 1'b0) begin n_fail++; $display("FAIL mid_dac: got %b want 0", audio_dac); end
    n_tests++; if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL mid_ucnt: got %0d want 0", underrun_count); end
    @(posedge clk_audio); #1;
    n_tests++; if ({audio_sclk, audio_lrck, audio_dac} !== 3'b000) begin n_fail++; $display("FAIL mid_hold: got %b want 000", {audio_sclk, audio_lrck, audio_dac}); end
    @(negedge clk_audio);
    reset_n = 1'b1;
    @(negedge clk_audio);
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", s_ready); end
    for (int i = 0; i < 256; i++) begin
      if (audio_dac) ones++;
      if (underrun) pulses++;
      @(negedge clk_audio);
    end
    n_tests++; if (ones != 0) begin n_fail++; $display("FAIL mid_mute: got %0d high cycles want 0", ones); end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL mid_underrun: got %0d pulses want 1", pulses); end
    n_tests++; if (underrun_count !== exp_ucnt()) begin n_fail++; $display("FAIL mid_ucnt_after: got %0d want %0d", underrun_count, exp_ucnt()); end
  endtask

  task automatic test_sample_w24();
    logic [W24-1:0] r;
    logic [31:0]    gl, gr;
    r = W24'($urandom);
    wait_cnt(30);
    s_valid24 = 1'b1; s_left24 = 24'h800001; s_right24 = r;
    @(negedge clk_audio);
    s_valid24 = 1'b0;
    wait_cnt(0);
    capture_frame(1'b1, gl, gr);
    n_tests++; if (gl !== 32'h0100_0002) begin n_fail++; $display("FAIL w24_left: got %h want 01000002", gl); end
    n_tests++; if (gr !== slot_vec(32'(r), W24)) begin n_fail++; $display("FAIL w24_right: got %h want %h", gr, slot_vec(32'(r), W24)); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_pair();
    test_back_to_back();
    test_random();
    test_push_at_255();
    test_reset_mid();
    test_sample_w24();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
